// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: RISC-V width codes, FSM states
// and the funct3 legality rule used at request acceptance.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Stores only have signed-form widths; loads additionally allow BU/HU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/mau_align.sv
// Combinational lane logic: merges store data into a read word and extracts
// and extends load data from a word according to funct3 and the byte lane.
module mau_align
  import mau_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = rd_word[{lane, 3'b000} +: 8];
    sel_h = lane[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3)
      F3_B:    load_data = {{24{sel_b[7]}}, sel_b};
      F3_H:    load_data = {{16{sel_h[15]}}, sel_h};
      F3_BU:   load_data = {24'h0, sel_b};
      F3_HU:   load_data = {16'h0, sel_h};
      default: load_data = rd_word;
    endcase

    store_word = rd_word;
    case (funct3)
      F3_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port word memory with combinational read.
// Define MAU_MISALIGN_CHECK_EN to fault misaligned H/W accesses instead of aligning them.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // Handshakes: a request transfers on a cycle with req_valid && req_ready; a
  // response transfers on rsp_valid && rsp_ready and is held unchanged until then.
  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [31:0] idx_q;
  logic [31:0] wdata_q;
  logic        mem_we_q;

  logic [31:0] eff_addr;
  logic [31:0] req_idx;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_ready = (state == S_IDLE);
  // Gated so that a reset arriving during WRITE suppresses the write at that edge.
  assign mem_we    = mem_we_q & ~reset;

  always_comb begin
    eff_addr = req_addr;
    if (req_funct3[1:0] == 2'b01)      eff_addr[0]   = 1'b0;
    else if (req_funct3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
    req_idx = {2'b00, eff_addr[31:2]};

    req_err = !f3_legal(req_we, req_funct3) || (req_idx >= DEPTH_W);
`ifdef MAU_MISALIGN_CHECK_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  mau_align u_align (
    .funct3     (f3_q),
    .lane       (lane_q),
    .rd_word    (mem_data_in),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
      idx_q        <= 32'h0;
      wdata_q      <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_address  <= 32'h0;
      mem_data_out <= 32'h0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_error    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            lane_q  <= eff_addr[1:0];
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            if (req_err) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (req_we && req_funct3 == F3_W) begin
              state        <= S_WRITE;
              mem_we_q     <= 1'b1;
              mem_address  <= req_idx;
              mem_data_out <= req_wdata;
            end else begin
              // Loads and sub-word stores both need the current word first.
              state       <= S_READ;
              mem_address <= req_idx;
            end
          end
        end
        S_READ: begin
          if (we_q) begin
            state        <= S_WRITE;
            mem_we_q     <= 1'b1;
            mem_data_out <= store_word;
          end else begin
            state       <= S_RESP;
            mem_address <= 32'h0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= load_data;
            rsp_error   <= 1'b0;
          end
        end
        S_WRITE: begin
          state        <= S_RESP;
          mem_we_q     <= 1'b0;
          mem_address  <= 32'h0;
          mem_data_out <= 32'h0;
          rsp_valid    <= 1'b1;
          rsp_rdata    <= 32'h0;
          rsp_error    <= 1'b0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-arithmetic reference model, per-cycle monitor,
// directed corner cases and randomized load/store traffic.
module tb_mem_access_unit;

  localparam int DEPTH = 32;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .mem_we       (mem_we),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- memory and reference memory ----------------
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        poke_en;
  logic [4:0]  poke_idx;
  logic [31:0] poke_val;

  assign mem_data_in = (mem_address < DEPTH) ? mem[mem_address[4:0]] : 32'h0;

  always @(posedge clock) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (mem_we && mem_address < DEPTH) mem[mem_address[4:0]] <= mem_data_out;
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endfunction

  // ---------------- behavioural model ----------------
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                                output int lat, output logic [31:0] idx, output logic [31:0] wword);
    int sz, off;
    logic [31:0] word, mask, v;
    sz  = 1 << f3[1:0];
    err = we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    idx = a >> 2;
    if (idx >= DEPTH) err = 1'b1;
`ifdef MAU_MISALIGN_CHECK_EN
    if (!err && (a % sz) != 0) err = 1'b1;
`endif
    off  = int'(a[1:0]) - (int'(a[1:0]) % sz);
    word = err ? 32'h0 : ref_mem[idx[4:0]];
    mask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (word >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    rdata = (err || we) ? 32'h0 : v;
    wword = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    lat   = err ? 1 : (!we ? 2 : (sz == 4 ? 2 : 3));
  endfunction

  // ---------------- monitor / compare process ----------------
  logic        busy = 1'b0;
  int          d;
  int          acc_cnt = 0;
  logic        e_we, e_err;
  logic [31:0] e_rdata, e_idx, e_wword;
  int          e_lat;

  always @(negedge clock) begin
    if (reset) begin
      chk("mem_we_in_reset", {31'h0, mem_we}, 32'h0);
      busy = 1'b0;
    end else if (!busy) begin
      chk("idle_req_ready", {31'h0, req_ready}, 32'h1);
      chk("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("idle_mem_we", {31'h0, mem_we}, 32'h0);
      chk("idle_mem_address", mem_address, 32'h0);
      if (req_valid && !poke_en) begin
        e_we = req_we;
        model(req_we, req_funct3, req_addr, req_wdata, e_err, e_rdata, e_lat, e_idx, e_wword);
        busy = 1'b1;
        d = 0;
        acc_cnt++;
      end
    end else begin
      logic exp_wr;
      d++;
      exp_wr = e_we && !e_err && (d == e_lat - 1);
      chk("busy_req_ready", {31'h0, req_ready}, 32'h0);
      chk("mem_we", {31'h0, mem_we}, {31'h0, exp_wr});
      chk("mem_address", mem_address, (d < e_lat) ? e_idx : 32'h0);
      if (exp_wr) begin
        chk("mem_data_out", mem_data_out, e_wword);
        ref_mem[e_idx[4:0]] = e_wword;
      end
      chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, (d >= e_lat)});
      if (d >= e_lat) begin
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_error", {31'h0, rsp_error}, {31'h0, e_err});
        if (rsp_ready) busy = 1'b0;
      end
    end
  end

  // ---------------- response-side driver ----------------
  logic hold_rsp = 1'b0;
  always @(posedge clock) begin
    #1;
    rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input int i, input logic [31:0] v);
    poke_en  = 1'b1;
    poke_idx = 5'(i);
    poke_val = v;
    ref_mem[i] = v;
    @(posedge clock); #1;
    poke_en = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int start, n;
    start = acc_cnt;
    n = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    while (acc_cnt == start && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    if (acc_cnt == start) chk("accept_timeout", 32'(n), 32'(0));
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 32'(n), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        p_err;
    logic [31:0] p_rdata, p_idx, p_wword;
    int          p_lat;

    reset = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    poke_en = 1'b0;
    poke_idx = 5'h0;
    poke_val = 32'h0;
    @(posedge clock); #1;
    for (int i = 0; i < DEPTH; i++) poke(i, $urandom());
    reset = 1'b0;
    @(negedge clock);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_error", {31'h0, rsp_error}, 32'h0);
    chk("reset_mem_data_out", mem_data_out, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clock); #1;

    // LB from a negative byte lane
    poke(1, 32'h1234_80FF);
    model(1'b0, 3'b000, 32'h5, 32'h0, p_err, p_rdata, p_lat, p_idx, p_wword);
    chk("pin_lb_rdata", p_rdata, 32'hFFFF_FF80);
    chk("pin_lb_lat", 32'(p_lat), 32'd2);
    txn(1'b0, 3'b000, 32'h5, 32'h0);
    wait_idle();

    // SB merges into lane 2
    poke(1, 32'h1122_3344);
    model(1'b1, 3'b000, 32'h6, 32'h0000_00AB, p_err, p_rdata, p_lat, p_idx, p_wword);
    chk("pin_sb_word", p_wword, 32'h11AB_3344);
    chk("pin_sb_lat", 32'(p_lat), 32'd3);
    txn(1'b1, 3'b000, 32'h6, 32'h0000_00AB);
    wait_idle();
    chk("sb_mem_word1", mem[1], 32'h11AB_3344);

    // SW out of range
    model(1'b1, 3'b010, 32'h80, 32'hDEAD_BEEF, p_err, p_rdata, p_lat, p_idx, p_wword);
    chk("pin_sw_oob_err", {31'h0, p_err}, 32'h1);
    chk("pin_sw_oob_lat", 32'(p_lat), 32'd1);
    txn(1'b1, 3'b010, 32'h80, 32'hDEAD_BEEF);
    wait_idle();

    // LW misaligned
    model(1'b0, 3'b010, 32'h6, 32'h0, p_err, p_rdata, p_lat, p_idx, p_wword);
`ifdef MAU_MISALIGN_CHECK_EN
    chk("pin_lw_mis_err", {31'h0, p_err}, 32'h1);
`else
    chk("pin_lw_mis_rdata", p_rdata, 32'h11AB_3344);
`endif
    txn(1'b0, 3'b010, 32'h6, 32'h0);
    wait_idle();

    // Response back-pressure
    hold_rsp = 1'b1;
    @(posedge clock); #1;
    txn(1'b0, 3'b010, 32'h4, 32'h0);
    @(posedge clock); #1;
    repeat (3) begin
      @(negedge clock);
      chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
      chk("stall_rsp_rdata", rsp_rdata, 32'h11AB_3344);
    end
    hold_rsp = 1'b0;
    @(posedge clock); #1;
    wait_idle();

    // Reset while in WRITE
    poke(3, 32'h5566_7788);
    txn(1'b1, 3'b010, 32'hC, 32'hDEAD_BEEF);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("post_reset_mem_we", {31'h0, mem_we}, 32'h0);
    chk("post_reset_mem_data_out", mem_data_out, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    chk("post_reset_mem_word3", mem[3], 32'h5566_7788);

    // Randomized traffic, requests offered back-to-back
    for (int t = 0; t < 400; t++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          r = $urandom_range(0, 4);
          f3 = (r < 3) ? 3'(r) : 3'(r + 1);
        end
      end else f3 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom();
      else if (r == 1) a = 32'(DEPTH * 4 + $urandom_range(0, 31));
      else             a = 32'($urandom_range(0, DEPTH * 4 - 1));
      txn(we, f3, a, $urandom());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
    wait_idle();
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
